increment_term_generator: RTL and testbench

Parametrised successor to the per-element increment-term calculator in the beamforming delay path. For one focal point it generates the comparator term pair K_n± = A0·(2n+1) ∓ C0 for n = 0..num_terms−1, where C0 = x_scale·cos(angle) comes from an external shared CORDIC unit through a request/done handshake. Terms stream out over a valid/ready interface at up to one pair per cycle. Downstream delay comparators consume the stream.

---
 rtl/increment_term_generator.sv | 198 +++++++++++++++++++
 tb/tb_increment_term_generator.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/increment_term_generator.sv
// Streams the comparator term pairs K_n+/- = A0*(2n+1) -/+ C0 for one focal point, with C0 fetched from a shared CORDIC.
// Optional saturating arithmetic: define INCR_TERM_SAT_EN (default build wraps in two's complement).
module increment_term_generator #(
  parameter int DW_INTEGER   = 18,
  parameter int DW_FRACTION  = 6,
  parameter int NUM_ELEMENTS = 64,
  parameter int DW_ANGLE     = 8,
  parameter int DW_R0        = 12,
  parameter int A0_Q         = 1054,
  parameter int XSCALE_Q     = 8433,
  localparam int DW          = DW_INTEGER + DW_FRACTION,
  localparam int CW          = $clog2(NUM_ELEMENTS / 2) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                initiate,
  input  logic                abort,
  input  logic [DW_R0-1:0]    r_0,
  input  logic [DW_ANGLE-1:0] angle,
  input  logic [CW-1:0]       num_terms,
  output logic                cordic_start,
  output logic [DW_ANGLE-1:0] cordic_angle,
  output logic [DW-1:0]       cordic_x_scale,
  input  logic                cordic_done,
  input  logic [DW-1:0]       cordic_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DW-1:0]       term_pos,
  output logic [DW-1:0]       term_neg,
  output logic [CW-2:0]       term_index,
  output logic                last,
  output logic                busy,
  output logic                done,
  output logic [1:0]          dbg_state
);

  // Handshake: a pair transfers on a rising clk edge where out_valid && out_ready; while
  // out_valid is high and out_ready low, every term output holds stable.
  typedef enum logic [1:0] {IDLE, REQ, WAITC, EMIT} state_e;

  localparam logic [CW-1:0] MAX_TERMS = CW'(NUM_ELEMENTS / 2);
  localparam logic [DW-1:0] A0_TERM   = DW'(A0_Q);
  localparam logic [DW-1:0] A0_STEP   = DW'(2 * A0_Q);
  localparam int            XW        = DW_R0 + 32;

  state_e                state_q;
  logic                  cordic_start_q;
  logic [DW_ANGLE-1:0]   angle_q;
  logic [DW-1:0]         x_scale_q;
  logic [CW-1:0]         count_q;
  logic                  out_valid_q;
  logic [DW-1:0]         term_pos_q;
  logic [DW-1:0]         term_neg_q;
  logic [CW-2:0]         index_q;
  logic                  last_q;
  logic                  done_q;

  logic [CW-1:0]         count_d;
  logic [XW-1:0]         xprod;
  logic [DW-1:0]         x_scale_d;
  logic [DW-1:0]         init_pos_d;
  logic [DW-1:0]         init_neg_d;
  logic [DW-1:0]         step_pos_d;
  logic [DW-1:0]         step_neg_d;
  logic                  last_next;

  assign count_d   = (num_terms > MAX_TERMS) ? MAX_TERMS : num_terms;
  assign xprod     = XW'(r_0) * XW'(XSCALE_Q);
  assign x_scale_d = DW'(xprod >> 4);
  assign last_next = (({1'b0, index_q} + CW'(1)) == (count_q - CW'(1)));

`ifdef INCR_TERM_SAT_EN
  // Sums are formed one bit wider; disagreement of the top two bits flags overflow.
  function automatic logic [DW:0] sext(input logic [DW-1:0] v);
    return {v[DW-1], v};
  endfunction

  function automatic logic ovf(input logic [DW:0] s);
    return s[DW] ^ s[DW-1];
  endfunction

  function automatic logic [DW-1:0] clamp(input logic [DW:0] s);
    if (!ovf(s)) return s[DW-1:0];
    return s[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  endfunction

  logic [DW:0] init_pos_s, init_neg_s, step_pos_s, step_neg_s;
  logic        pos_sat_q, neg_sat_q;

  assign init_pos_s = sext(A0_TERM) - sext(cordic_result);
  assign init_neg_s = sext(A0_TERM) + sext(cordic_result);
  assign step_pos_s = sext(term_pos_q) + sext(A0_STEP);
  assign step_neg_s = sext(term_neg_q) + sext(A0_STEP);
  assign init_pos_d = clamp(init_pos_s);
  assign init_neg_d = clamp(init_neg_s);
  // A clamped term is frozen for the remainder of the run.
  assign step_pos_d = pos_sat_q ? term_pos_q : clamp(step_pos_s);
  assign step_neg_d = neg_sat_q ? term_neg_q : clamp(step_neg_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_sat_q <= 1'b0;
      neg_sat_q <= 1'b0;
    end else if (!abort) begin
      if (state_q == WAITC && cordic_done) begin
        pos_sat_q <= ovf(init_pos_s);
        neg_sat_q <= ovf(init_neg_s);
      end else if (state_q == EMIT && out_ready && !last_q) begin
        pos_sat_q <= pos_sat_q | ovf(step_pos_s);
        neg_sat_q <= neg_sat_q | ovf(step_neg_s);
      end
    end
  end
`else
  assign init_pos_d = A0_TERM - cordic_result;
  assign init_neg_d = A0_TERM + cordic_result;
  assign step_pos_d = term_pos_q + A0_STEP;
  assign step_neg_d = term_neg_q + A0_STEP;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cordic_start_q <= 1'b0;
      angle_q        <= '0;
      x_scale_q      <= '0;
      count_q        <= '0;
      out_valid_q    <= 1'b0;
      term_pos_q     <= '0;
      term_neg_q     <= '0;
      index_q        <= '0;
      last_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      cordic_start_q <= 1'b0;
      done_q         <= 1'b0;
      if (abort) begin
        state_q     <= IDLE;
        out_valid_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (initiate) begin
              angle_q   <= angle;
              x_scale_q <= x_scale_d;
              count_q   <= count_d;
              if (count_d == '0) begin
                done_q <= 1'b1;
              end else begin
                state_q        <= REQ;
                cordic_start_q <= 1'b1;
              end
            end
          end
          REQ: state_q <= WAITC;
          WAITC: begin
            if (cordic_done) begin
              term_pos_q  <= init_pos_d;
              term_neg_q  <= init_neg_d;
              index_q     <= '0;
              last_q      <= (count_q == CW'(1));
              out_valid_q <= 1'b1;
              state_q     <= EMIT;
            end
          end
          EMIT: begin
            if (out_ready) begin
              if (last_q) begin
                state_q     <= IDLE;
                out_valid_q <= 1'b0;
                done_q      <= 1'b1;
              end else begin
                term_pos_q <= step_pos_d;
                term_neg_q <= step_neg_d;
                index_q    <= index_q + 1'b1;
                last_q     <= last_next;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign cordic_start   = cordic_start_q;
  assign cordic_angle   = angle_q;
  assign cordic_x_scale = x_scale_q;
  assign out_valid      = out_valid_q;
  assign term_pos       = term_pos_q;
  assign term_neg       = term_neg_q;
  assign term_index     = index_q;
  assign last           = last_q;
  assign busy           = (state_q != IDLE);
  assign done           = done_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_increment_term_generator.sv
// Scoreboard bench for increment_term_generator: expected term pairs are queued when the CORDIC result is driven.
module tb_increment_term_generator;
  localparam int     DW   = 24;
  localparam int     CW   = 6;
  localparam longint MAXV = 64'sd8388607;
  localparam longint MINV = -64'sd8388608;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          initiate = 1'b0;
  logic          abort = 1'b0;
  logic [11:0]   r_0 = '0;
  logic [7:0]    angle = '0;
  logic [CW-1:0] num_terms = '0;
  logic          cordic_done = 1'b0;
  logic [DW-1:0] cordic_result = '0;
  logic          out_ready = 1'b1;
  logic          cordic_start, out_valid, last, busy, done;
  logic [7:0]    cordic_angle;
  logic [DW-1:0] cordic_x_scale, term_pos, term_neg;
  logic [CW-2:0] term_index;
  logic [1:0]    dbg_state;

  increment_term_generator dut (
    .clk(clk), .rst_n(rst_n), .initiate(initiate), .abort(abort), .r_0(r_0), .angle(angle),
    .num_terms(num_terms), .cordic_start(cordic_start), .cordic_angle(cordic_angle),
    .cordic_x_scale(cordic_x_scale), .cordic_done(cordic_done), .cordic_result(cordic_result),
    .out_valid(out_valid), .out_ready(out_ready), .term_pos(term_pos), .term_neg(term_neg),
    .term_index(term_index), .last(last), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [53:0] exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          beats = 0;
  int          last_hs = 0;
  int          done_pulses = 0;
  logic        stall_prev = 1'b0;
  logic [53:0] held;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor: a beat transfers at the posedge following a negedge where valid && ready.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_pulses++;
      if (stall_prev && out_valid)
        check_val("hold", {10'd0, term_pos, term_neg, term_index, last}, {10'd0, held});
      stall_prev = out_valid && !out_ready;
      held       = {term_pos, term_neg, term_index, last};
      if (out_valid && out_ready) begin
        check_val("sb_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0)
          check_val("beat", {10'd0, term_pos, term_neg, term_index, last}, {10'd0, exp_q.pop_front()});
        beats++;
        if (last) last_hs = cyc + 1;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  task automatic push_exp(input int cnt, input logic [DW-1:0] res);
    longint p, q, r;
    bit ps, qs;
    logic [DW-1:0] pt, qt;
    r = longint'($signed(res));
    p = 1054 - r;
    q = 1054 + r;
    ps = 1'b0;
    qs = 1'b0;
    for (int i = 0; i < cnt; i++) begin
      if (i > 0) begin
        if (!ps) p = p + 2108;
        if (!qs) q = q + 2108;
      end
`ifdef INCR_TERM_SAT_EN
      if (p > MAXV) begin p = MAXV; ps = 1'b1; end
      else if (p < MINV) begin p = MINV; ps = 1'b1; end
      if (q > MAXV) begin q = MAXV; qs = 1'b1; end
      else if (q < MINV) begin q = MINV; qs = 1'b1; end
`else
      pt = p[DW-1:0];
      qt = q[DW-1:0];
      p = longint'($signed(pt));
      q = longint'($signed(qt));
`endif
      exp_q.push_back({p[DW-1:0], q[DW-1:0], i[4:0], (i == cnt - 1)});
    end
  endtask

  task automatic run_job(input int n, input logic [DW-1:0] res, input logic [11:0] r0,
                         input logic [7:0] ang, input int stall_idx);
    int cnt, stalls, guard, b0, d0;
    longint xs;
    cnt = (n > 32) ? 32 : n;
    stalls = 0;
    xs = (longint'(r0) * 8433) >>> 4;
    @(posedge clk); #1;
    initiate = 1'b1; num_terms = n[CW-1:0]; r_0 = r0; angle = ang;
    @(posedge clk); #1;
    initiate = 1'b0;
    num_terms = CW'($urandom_range(0, 63));
    r_0 = 12'($urandom_range(0, 4095));
    angle = 8'($urandom_range(0, 255));
    b0 = beats;
    d0 = done_pulses;
    check_val("cordic_angle", 64'(cordic_angle), 64'(ang));
    check_val("x_scale", 64'(cordic_x_scale), 64'(xs[DW-1:0]));
    if (cnt == 0) begin
      check_val("zero_done", 64'(done), 64'd1);
      check_val("zero_cstart", 64'(cordic_start), 64'd0);
      check_val("zero_busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      check_val("zero_valid", 64'(out_valid), 64'd0);
      check_val("zero_done_pulse", 64'(done), 64'd0);
      return;
    end
    check_val("cstart", 64'(cordic_start), 64'd1);
    check_val("busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    check_val("cstart_pulse", 64'(cordic_start), 64'd0);
    @(posedge clk); #1;
    check_val("waitc_valid", 64'(out_valid), 64'd0);
    push_exp(cnt, res);
    cordic_done = 1'b1;
    cordic_result = res;
    @(posedge clk); #1;
    cordic_done = 1'b0;
    cordic_result = DW'($urandom);
    check_val("valid_lat", 64'(out_valid), 64'd1);
    guard = 0;
    while (!done && guard < 300) begin
      out_ready = !(stall_idx >= 0 && out_valid && int'(term_index) == stall_idx && stalls < 3);
      if (!out_ready) stalls++;
      @(posedge clk); #1;
      guard++;
    end
    out_ready = 1'b1;
    check_val("done_seen", 64'(done), 64'd1);
    check_val("done_lat", 64'(cyc), 64'(last_hs));
    check_val("busy_end", 64'(busy), 64'd0);
    check_val("beat_count", 64'(beats - b0), 64'(cnt));
    check_val("sb_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
    check_val("done_once", 64'(done_pulses - d0), 64'd1);
  endtask

  task automatic launch(input int n, input logic [DW-1:0] res);
    @(posedge clk); #1;
    initiate = 1'b1; num_terms = n[CW-1:0]; r_0 = 12'd1234; angle = 8'd77;
    @(posedge clk); #1;
    initiate = 1'b0;
    @(posedge clk); #1;
    push_exp(n, res);
    cordic_done = 1'b1; cordic_result = res;
    @(posedge clk); #1;
    cordic_done = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, d0, guard;
    #1;
    check_val("rst_valid", 64'(out_valid), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    check_val("rst_terms", {16'd0, term_pos, term_neg}, 64'd0);
    check_val("rst_cstart", 64'(cordic_start), 64'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_job(3, 24'd0, 12'd0, 8'd0, -1);
    run_job(2, 24'd100, 12'd100, 8'd45, -1);
    run_job(4, -24'sd500, 12'd4095, 8'd200, 1);
    run_job(0, 24'd5, 12'd10, 8'd3, -1);
    run_job(63, 24'd12345, 12'd777, 8'd9, -1);
    run_job(1, 24'h7FFFFF, 12'd1, 8'd1, -1);
    run_job(3, 24'h800000, 12'd2, 8'd2, -1);
    for (int k = 0; k < 4; k++)
      run_job($urandom_range(1, 40), DW'($urandom), 12'($urandom_range(0, 4095)),
              8'($urandom_range(0, 255)), $urandom_range(0, 3));

    // Abort while waiting for the CORDIC; a late cordic_done must be ignored.
    d0 = done_pulses;
    @(posedge clk); #1;
    initiate = 1'b1; num_terms = 6'd5;
    @(posedge clk); #1;
    initiate = 1'b0;
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_val("abort_w_valid", 64'(out_valid), 64'd0);
    check_val("abort_w_busy", 64'(busy), 64'd0);
    cordic_done = 1'b1;
    @(posedge clk); #1;
    cordic_done = 1'b0;
    repeat (3) @(posedge clk); #1;
    check_val("stray_done_valid", 64'(out_valid), 64'd0);
    check_val("abort_w_nodone", 64'(done_pulses - d0), 64'd0);

    // Abort mid-stream: the beat sharing the abort edge still counts as delivered.
    b0 = beats;
    d0 = done_pulses;
    launch(8, 24'd321);
    guard = 0;
    while (term_index != 5'd3 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    check_val("abort_e_reach", 64'(term_index), 64'd3);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check_val("abort_e_valid", 64'(out_valid), 64'd0);
    check_val("abort_e_busy", 64'(busy), 64'd0);
    check_val("abort_e_beats", 64'(beats - b0), 64'd4);
    exp_q.delete();
    repeat (4) @(posedge clk); #1;
    check_val("abort_e_nodone", 64'(done_pulses - d0), 64'd0);

    // Asynchronous reset mid-stream.
    launch(8, 24'd77);
    repeat (2) @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_val("arst_valid", 64'(out_valid), 64'd0);
    check_val("arst_terms", {16'd0, term_pos, term_neg}, 64'd0);
    check_val("arst_busy", 64'(busy), 64'd0);
    check_val("arst_xscale", 64'(cordic_x_scale), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_job(5, -24'sd1000, 12'd300, 8'd12, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
